tl_reg_bridge: RTL and testbench



---
 rtl/tl_pkg.sv | 30 +++
 rtl/tl_reg_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_tl_reg_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// TileLink-UL opcode encodings shared by TL-facing blocks.
package tl_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL      = 3'd0,
    A_PUT_PARTIAL   = 3'd1,
    A_ARITH         = 3'd2,
    A_LOGICAL       = 3'd3,
    A_GET           = 3'd4,
    A_INTENT        = 3'd5,
    A_ACQUIRE_BLOCK = 3'd6,
    A_ACQUIRE_PERM  = 3'd7
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } tl_d_op_e;

  // Response opcode a device returns for each request opcode; Acquire falls to AccessAck.
  function automatic tl_d_op_e d_op_for(input tl_a_op_e op);
    case (op)
      A_GET, A_ARITH, A_LOGICAL: d_op_for = D_ACCESS_ACK_DATA;
      A_INTENT:                  d_op_for = D_HINT_ACK;
      default:                   d_op_for = D_ACCESS_ACK;
    endcase
  endfunction

endpackage

// File: rtl/tl_reg_bridge.sv
// TL-UL responder for the io port: one register access per request, anything
// unsupported or stuck is answered with a denied response.
module tl_reg_bridge
  import tl_pkg::*;
#(
  parameter int                   DataWidth     = 64,
  parameter int                   AddrWidth     = 56,
  parameter int                   SourceWidth   = 5,
  parameter int                   SinkWidth     = 1,
  parameter int                   SizeWidth     = 3,
  parameter int                   RegAddrWidth  = 16,
  parameter logic [AddrWidth-1:0] AddrBase      = 'h10000000,
  parameter logic [AddrWidth-1:0] AddrMask      = 'hFFFF,
  parameter int                   TimeoutCycles = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     host_a_valid,
  output logic                     host_a_ready,
  input  logic [2:0]               host_a_opcode,
  input  logic [2:0]               host_a_param,
  input  logic [SizeWidth-1:0]     host_a_size,
  input  logic [SourceWidth-1:0]   host_a_source,
  input  logic [AddrWidth-1:0]     host_a_address,
  input  logic [DataWidth/8-1:0]   host_a_mask,
  input  logic                     host_a_corrupt,
  input  logic [DataWidth-1:0]     host_a_data,

  output logic                     host_d_valid,
  input  logic                     host_d_ready,
  output logic [2:0]               host_d_opcode,
  output logic [2:0]               host_d_param,
  output logic [SizeWidth-1:0]     host_d_size,
  output logic [SourceWidth-1:0]   host_d_source,
  output logic [SinkWidth-1:0]     host_d_sink,
  output logic                     host_d_denied,
  output logic                     host_d_corrupt,
  output logic [DataWidth-1:0]     host_d_data,

  output logic                     reg_req_o,
  output logic                     reg_we_o,
  output logic [RegAddrWidth-1:0]  reg_addr_o,
  output logic [DataWidth-1:0]     reg_wdata_o,
  output logic [DataWidth/8-1:0]   reg_be_o,
  input  logic                     reg_ready_i,
  input  logic [DataWidth-1:0]     reg_rdata_i,
  input  logic                     reg_err_i
);

  localparam int BeatBytes   = DataWidth / 8;
  localparam int BeatSizeLog = $clog2(BeatBytes);
  localparam int MaxSize     = (1 << SizeWidth) - 1;
  localparam int BeatCntW    = MaxSize - BeatSizeLog + 1;
  localparam int TimerW      = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REG   = 3'd1,
    RESP  = 3'd2,
    DRAIN = 3'd3,
    ERRD  = 3'd4
  } state_e;

  // Number of data beats a burst of 2^size bytes occupies on this bus.
  function automatic logic [BeatCntW-1:0] beats(input logic [SizeWidth-1:0] size);
    if (size > SizeWidth'(BeatSizeLog)) begin
      beats = BeatCntW'(1) << (size - SizeWidth'(BeatSizeLog));
    end else begin
      beats = BeatCntW'(1);
    end
  endfunction

  state_e                  state_q,  state_d;
  logic [SourceWidth-1:0]  source_q, source_d;
  logic [SizeWidth-1:0]    size_q,   size_d;
  tl_d_op_e                d_op_q,   d_op_d;
  logic                    denied_q, denied_d;
  logic [DataWidth-1:0]    data_q,   data_d;
  logic                    we_q,     we_d;
  logic [RegAddrWidth-1:0] addr_q,   addr_d;
  logic [DataWidth-1:0]    wdata_q,  wdata_d;
  logic [BeatBytes-1:0]    be_q,     be_d;
  logic [TimerW-1:0]       timer_q,  timer_d;
  logic [BeatCntW-1:0]     beat_q,   beat_d;

  tl_a_op_e a_op;
  logic     a_fire;
  logic     d_fire;
  logic     a_single;
  logic     in_window;
  logic     legal;
  logic     unused_param;

  assign a_op      = tl_a_op_e'(host_a_opcode);
  assign a_fire    = host_a_valid && host_a_ready;
  assign d_fire    = host_d_valid && host_d_ready;
  assign a_single  = host_a_size <= SizeWidth'(BeatSizeLog);
  assign in_window = (host_a_address & ~AddrMask) == AddrBase;
  assign legal     = (a_op inside {A_GET, A_PUT_FULL, A_PUT_PARTIAL}) && a_single &&
                     in_window && !host_a_corrupt;
  assign unused_param = ^host_a_param;

  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave a value unassigned and infer a latch.
    state_d  = state_q;
    source_d = source_q;
    size_d   = size_q;
    d_op_d   = d_op_q;
    denied_d = denied_q;
    data_d   = data_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    timer_d  = timer_q;
    beat_d   = beat_q;

    unique case (state_q)
      IDLE: begin
        if (a_fire) begin
          source_d = host_a_source;
          size_d   = host_a_size;
          d_op_d   = d_op_for(a_op);
          denied_d = 1'b1;
          data_d   = '0;
          timer_d  = '0;
          beat_d   = '0;
          if (legal) begin
            denied_d = 1'b0;
            we_d     = a_op != A_GET;
            addr_d   = RegAddrWidth'(host_a_address & AddrMask);
            wdata_d  = host_a_data;
            be_d     = host_a_mask;
            state_d  = REG;
          end else if (!a_single &&
                       (a_op inside {A_PUT_FULL, A_PUT_PARTIAL, A_ARITH, A_LOGICAL})) begin
            // The remaining request beats must be swallowed before answering.
            beat_d  = beats(host_a_size) - BeatCntW'(1);
            state_d = DRAIN;
          end else begin
            if (!a_single && a_op == A_GET) begin
              beat_d = beats(host_a_size) - BeatCntW'(1);
            end
            state_d = RESP;
          end
        end
      end

      REG: begin
        if (reg_ready_i) begin
          denied_d = reg_err_i;
          data_d   = reg_err_i ? '0 : reg_rdata_i;
          state_d  = RESP;
        end else if (timer_q == TimerW'(TimeoutCycles - 1)) begin
          denied_d = 1'b1;
          data_d   = '0;
          state_d  = RESP;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      DRAIN: begin
        if (a_fire) begin
          beat_d = beat_q - BeatCntW'(1);
          if (beat_q == BeatCntW'(1)) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        if (d_fire) begin
          state_d = (beat_q != '0) ? ERRD : IDLE;
        end
      end

      ERRD: begin
        if (d_fire) begin
          beat_d = beat_q - BeatCntW'(1);
          if (beat_q == BeatCntW'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      source_q <= '0;
      size_q   <= '0;
      d_op_q   <= D_ACCESS_ACK;
      denied_q <= 1'b0;
      data_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      timer_q  <= '0;
      beat_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q  <= state_d;
      source_q <= source_d;
      size_q   <= size_d;
      d_op_q   <= d_op_d;
      denied_q <= denied_d;
      data_q   <= data_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      timer_q  <= timer_d;
      beat_q   <= beat_d;
    end
  end

  // Ready is masked by reset directly so nothing is accepted while reset is held.
  assign host_a_ready   = !rst_i && (state_q == IDLE || state_q == DRAIN);

  assign host_d_valid   = (state_q == RESP) || (state_q == ERRD);
  assign host_d_opcode  = d_op_q;
  assign host_d_param   = 3'd0;
  assign host_d_size    = size_q;
  assign host_d_source  = source_q;
  assign host_d_sink    = '0;
  assign host_d_denied  = denied_q;
  assign host_d_corrupt = denied_q && (d_op_q == D_ACCESS_ACK_DATA);
  assign host_d_data    = data_q;

  assign reg_req_o   = state_q == REG;
  assign reg_we_o    = we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_be_o    = be_q;

endmodule

// File: tb/tb_tl_reg_bridge.sv
// Scoreboard bench for tl_reg_bridge: stimulus queues expected D beats and
// register accesses; a D monitor and a register-slave model pop and compare.
module tb_tl_reg_bridge;
  import tl_pkg::*;

  localparam logic [55:0] BASE = 56'h1000_0000;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [4:0]  source;
    logic        sink;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } d_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    int          wait_cycles;
    logic [63:0] rdata;
    logic        err;
  } r_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        host_a_valid, host_a_ready;
  logic [2:0]  host_a_opcode, host_a_param, host_a_size;
  logic [4:0]  host_a_source;
  logic [55:0] host_a_address;
  logic [7:0]  host_a_mask;
  logic        host_a_corrupt;
  logic [63:0] host_a_data;
  logic        host_d_valid, host_d_ready;
  logic [2:0]  host_d_opcode, host_d_param, host_d_size;
  logic [4:0]  host_d_source;
  logic [0:0]  host_d_sink;
  logic        host_d_denied, host_d_corrupt;
  logic [63:0] host_d_data;
  logic        reg_req_o, reg_we_o;
  logic [15:0] reg_addr_o;
  logic [63:0] reg_wdata_o;
  logic [7:0]  reg_be_o;
  logic        reg_ready_i, reg_err_i;
  logic [63:0] reg_rdata_i;

  tl_reg_bridge #(.TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
    .host_a_opcode(host_a_opcode), .host_a_param(host_a_param),
    .host_a_size(host_a_size), .host_a_source(host_a_source),
    .host_a_address(host_a_address), .host_a_mask(host_a_mask),
    .host_a_corrupt(host_a_corrupt), .host_a_data(host_a_data),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
    .host_d_opcode(host_d_opcode), .host_d_param(host_d_param),
    .host_d_size(host_d_size), .host_d_source(host_d_source),
    .host_d_sink(host_d_sink), .host_d_denied(host_d_denied),
    .host_d_corrupt(host_d_corrupt), .host_d_data(host_d_data),
    .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o),
    .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i)
  );

  always #5 clk = ~clk;

  d_t dq[$];
  r_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  int a_fire_cyc, d_rise_cyc, d_fire_cyc, d_count;
  int req_cycles, req_starts, req_first_cyc, req_last_cyc, ready_cyc;

  d_t mon_got, mon_held, mon_exp;
  bit mon_stalled, mon_prev_v;
  r_t sl_cur;
  bit sl_busy;
  int sl_left;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic d_t mk_d(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src,
                              input logic denied, input logic corrupt, input logic [63:0] data);
    mk_d = '{opcode: op, param: 3'd0, size: size, source: src, sink: 1'b0,
             denied: denied, corrupt: corrupt, data: data};
  endfunction

  function automatic r_t mk_r(input logic we, input logic [15:0] addr, input logic [7:0] be,
                              input logic [63:0] wdata, input int wait_cycles,
                              input logic [63:0] rdata, input logic err);
    mk_r = '{we, addr, be, wdata, wait_cycles, rdata, err};
  endfunction

  // D-side monitor: compares every fired beat and checks payload stability while stalled.
  initial begin
    d_count = 0;
    mon_stalled = 0;
    mon_prev_v = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        mon_stalled = 0;
        mon_prev_v  = 0;
      end else begin
        mon_got = {host_d_opcode, host_d_param, host_d_size, host_d_source, host_d_sink,
                   host_d_denied, host_d_corrupt, host_d_data};
        if (host_d_valid && !mon_prev_v) d_rise_cyc = cyc;
        if (host_d_valid && mon_stalled) check("d_payload_held", mon_got, mon_held);
        if (host_d_valid && host_d_ready) begin
          check("d_beat_expected", dq.size() != 0, 1'b1);
          if (dq.size() != 0) begin
            mon_exp = dq.pop_front();
            check("d_beat", mon_got, mon_exp);
          end
          d_count++;
          d_fire_cyc  = cyc;
          mon_stalled = 0;
        end else if (host_d_valid) begin
          mon_stalled = 1;
          mon_held    = mon_got;
        end else begin
          mon_stalled = 0;
        end
        mon_prev_v = host_d_valid;
      end
    end
  end

  // Register slave: checks each new request against the queue and answers after its wait.
  initial begin
    reg_ready_i = 0; reg_rdata_i = '0; reg_err_i = 0;
    req_cycles = 0; req_starts = 0; sl_busy = 0; sl_left = 0;
    forever begin
      @(negedge clk);
      reg_ready_i = 0; reg_rdata_i = '0; reg_err_i = 0;
      if (rst_i || !reg_req_o) begin
        sl_busy = 0;
      end else begin
        req_cycles++;
        req_last_cyc = cyc;
        if (!sl_busy) begin
          sl_busy = 1;
          req_starts++;
          req_first_cyc = cyc;
          check("reg_access_expected", rq.size() != 0, 1'b1);
          if (rq.size() != 0) begin
            sl_cur = rq.pop_front();
            check("reg_we", reg_we_o, sl_cur.we);
            check("reg_addr", reg_addr_o, sl_cur.addr);
            check("reg_be", reg_be_o, sl_cur.be);
            if (sl_cur.we) check("reg_wdata", reg_wdata_o, sl_cur.wdata);
            sl_left = sl_cur.wait_cycles;
          end else begin
            sl_left = 1000;
          end
        end
        if (sl_left == 0) begin
          reg_ready_i = 1;
          reg_rdata_i = sl_cur.rdata;
          reg_err_i   = sl_cur.err;
          ready_cyc   = cyc;
          sl_busy     = 0;
        end else begin
          sl_left--;
        end
      end
    end
  end

  initial begin
    host_d_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       host_d_ready = 1'b1;
        1:       host_d_ready = 1'($urandom_range(0, 1));
        default: host_d_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src,
                        input logic [55:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic corrupt);
    int n = 0;
    host_a_valid = 1; host_a_opcode = op; host_a_size = size; host_a_source = src;
    host_a_address = addr; host_a_mask = mask; host_a_data = data; host_a_corrupt = corrupt;
    @(negedge clk);
    while (!host_a_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_accepted_in_budget", n < 200, 1'b1);
    a_fire_cyc = cyc;
    @(posedge clk); #1;
    host_a_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while ((dq.size() != 0 || rq.size() != 0 || host_d_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("responses_in_budget", n < budget, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int starts0, cnt0, n;
    rst_i = 1; host_a_valid = 0; host_a_opcode = 0; host_a_param = 0; host_a_size = 0;
    host_a_source = 0; host_a_address = 0; host_a_mask = 0; host_a_corrupt = 0; host_a_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", host_a_ready, 1'b0);
    check("rst_d_valid", host_d_valid, 1'b0);
    check("rst_reg_req", reg_req_o, 1'b0);
    check("rst_reg_addr", reg_addr_o, 16'h0);
    check("rst_d_data", host_d_data, 64'h0);
    @(posedge clk); #1;
    rst_i = 0;
    @(negedge clk);
    check("idle_a_ready", host_a_ready, 1'b1);
    @(posedge clk); #1;

    // Zero-wait read: D valid two cycles after the A-fire cycle (3-cycle round trip).
    rq.push_back(mk_r(1'b0, 16'h0008, 8'hFF, 64'h0, 0, 64'h0000_DEAD_BEEF_0123, 1'b0));
    dq.push_back(mk_d(D_ACCESS_ACK_DATA, 3'd3, 5'd5, 1'b0, 1'b0, 64'h0000_DEAD_BEEF_0123));
    send_a(A_GET, 3'd3, 5'd5, BASE + 56'h8, 8'hFF, 64'h0, 1'b0);
    wait_done(50);
    check("read_req_latency", req_first_cyc - a_fire_cyc, 1);
    check("read_round_trip", d_rise_cyc - a_fire_cyc, 2);

    // Partial write with two wait cycles.
    rq.push_back(mk_r(1'b1, 16'h0010, 8'h0F, 64'h1122_3344, 2, 64'h0, 1'b0));
    dq.push_back(mk_d(D_ACCESS_ACK, 3'd2, 5'd7, 1'b0, 1'b0, 64'h0));
    send_a(A_PUT_PARTIAL, 3'd2, 5'd7, BASE + 56'h10, 8'h0F, 64'h1122_3344, 1'b0);
    wait_done(50);
    check("write_d_after_ready", d_rise_cyc - ready_cyc, 1);

    // Out-of-window address: denied, no register access.
    starts0 = req_starts;
    dq.push_back(mk_d(D_ACCESS_ACK, 3'd3, 5'd3, 1'b1, 1'b0, 64'h0));
    send_a(A_PUT_FULL, 3'd3, 5'd3, 56'h2000_0000, 8'hFF, 64'hAA, 1'b0);
    wait_done(50);
    check("oow_no_reg_req", req_starts - starts0, 0);

    // Slave error on a read: denied, corrupt, data suppressed.
    rq.push_back(mk_r(1'b0, 16'h0020, 8'h0F, 64'h0, 0, 64'hFFFF, 1'b1));
    dq.push_back(mk_d(D_ACCESS_ACK_DATA, 3'd2, 5'd12, 1'b1, 1'b1, 64'h0));
    send_a(A_GET, 3'd2, 5'd12, BASE + 56'h20, 8'h0F, 64'h0, 1'b0);
    wait_done(50);

    // Intent is not forwarded: denied HintAck.
    starts0 = req_starts;
    dq.push_back(mk_d(D_HINT_ACK, 3'd3, 5'd4, 1'b1, 1'b0, 64'h0));
    send_a(A_INTENT, 3'd3, 5'd4, BASE + 56'h40, 8'hFF, 64'h0, 1'b0);
    wait_done(50);
    check("intent_no_reg_req", req_starts - starts0, 0);

    // Timeout: slave never answers, request held exactly 4 cycles.
    req_cycles = 0;
    rq.push_back(mk_r(1'b0, 16'h0030, 8'hFF, 64'h0, 1000, 64'h0, 1'b0));
    dq.push_back(mk_d(D_ACCESS_ACK_DATA, 3'd3, 5'd6, 1'b1, 1'b1, 64'h0));
    send_a(A_GET, 3'd3, 5'd6, BASE + 56'h30, 8'hFF, 64'h0, 1'b0);
    wait_done(50);
    check("timeout_req_cycles", req_cycles, 4);
    check("timeout_d_next_cycle", d_rise_cyc - req_last_cyc, 1);

    // PutFull of 32 bytes: four beats accepted, one denied AccessAck.
    starts0 = req_starts;
    dq.push_back(mk_d(D_ACCESS_ACK, 3'd5, 5'd9, 1'b1, 1'b0, 64'h0));
    for (int b = 0; b < 4; b++) send_a(A_PUT_FULL, 3'd5, 5'd9, BASE + 56'h40, 8'hFF, 64'(b), 1'b0);
    @(negedge clk);
    check("drain_stops_after_4", host_a_ready, 1'b0);
    wait_done(50);
    check("drain_no_reg_req", req_starts - starts0, 0);

    // Get of 64 bytes: eight denied data beats under random back-pressure.
    cnt0 = d_count;
    for (int b = 0; b < 8; b++) dq.push_back(mk_d(D_ACCESS_ACK_DATA, 3'd6, 5'd11, 1'b1, 1'b1, 64'h0));
    rdy_mode = 1;
    send_a(A_GET, 3'd6, 5'd11, BASE + 56'h80, 8'hFF, 64'h0, 1'b0);
    wait_done(400);
    check("get_burst_beats", d_count - cnt0, 8);
    rdy_mode = 0;

    // Back-to-back: next A accepted the cycle after the D fire.
    rq.push_back(mk_r(1'b0, 16'h0008, 8'hFF, 64'h0, 0, 64'h1111, 1'b0));
    rq.push_back(mk_r(1'b0, 16'h0010, 8'hFF, 64'h0, 0, 64'h2222, 1'b0));
    dq.push_back(mk_d(D_ACCESS_ACK_DATA, 3'd3, 5'd1, 1'b0, 1'b0, 64'h1111));
    dq.push_back(mk_d(D_ACCESS_ACK_DATA, 3'd3, 5'd2, 1'b0, 1'b0, 64'h2222));
    send_a(A_GET, 3'd3, 5'd1, BASE + 56'h8, 8'hFF, 64'h0, 1'b0);
    send_a(A_GET, 3'd3, 5'd2, BASE + 56'h10, 8'hFF, 64'h0, 1'b0);
    check("back_to_back_accept", a_fire_cyc - d_fire_cyc, 1);
    wait_done(50);

    // Reset while a response is stalled in RESP.
    rdy_mode = 2;
    rq.push_back(mk_r(1'b0, 16'h0008, 8'hFF, 64'h0, 0, 64'h5555, 1'b0));
    send_a(A_GET, 3'd3, 5'd2, BASE + 56'h8, 8'hFF, 64'h0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!host_d_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_d_valid_reached", host_d_valid, 1'b1);
    @(posedge clk); #1;
    rst_i = 1;
    @(negedge clk);
    @(negedge clk);
    check("abort_d_valid_dropped", host_d_valid, 1'b0);
    check("abort_reg_req_low", reg_req_o, 1'b0);
    check("abort_a_ready_in_reset", host_a_ready, 1'b0);
    @(posedge clk); #1;
    rst_i = 0;
    rdy_mode = 0;
    @(negedge clk);
    check("abort_a_ready_after", host_a_ready, 1'b1);
    check("abort_no_d_after", host_d_valid, 1'b0);
    check("abort_queues_empty", rq.size() + dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
